// File: rtl/tetris_gravity_timer_if.sv
// Bundle between the gravity timer and its surroundings: control pulses in; fall strobe, stats and FSM state out.
interface tetris_gravity_timer_if #(
    parameter int NUM_LINES  = 20,
    parameter int NUM_LEVELS = 16
);
    localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    // lines_cleared_valid is a one-cycle qualifier: lines_cleared is sampled only
    // while it is high, at most one per cycle, and the timer always accepts it (no ready).
    logic                 restart;
    logic                 any_input;
    logic                 pause_toggle;
    logic                 soft_drop;
    logic                 game_over;
    logic [NUM_LINES-1:0] lines_cleared;
    logic                 lines_cleared_valid;
    logic                 next_fall;
    logic                 running;
    logic                 paused;
    logic [LVL_W-1:0]     level;
    logic [15:0]          lines_total;
    logic [19:0]          score;
    logic [1:0]           state;

    modport master (
        output restart, any_input, pause_toggle, soft_drop, game_over,
               lines_cleared, lines_cleared_valid,
        input  next_fall, running, paused, level, lines_total, score, state
    );

    modport slave (
        input  restart, any_input, pause_toggle, soft_drop, game_over,
               lines_cleared, lines_cleared_valid,
        output next_fall, running, paused, level, lines_total, score, state
    );
endinterface

// File: rtl/tetris_gravity_timer.sv
// Gravity/level controller: gates play on first input, strobes next_fall at a level-dependent
// period (with pause and soft drop), and keeps lines, level and score from cleared-row masks.
module tetris_gravity_timer #(
    parameter int CNT_WIDTH       = 26,
    parameter int NUM_LINES       = 20,
    parameter int NUM_LEVELS      = 16,
    parameter int LINES_PER_LEVEL = 10,
    parameter int BASE_PERIOD     = 50_000_000,
    parameter int PERIOD_STEP     = 3_000_000,
    parameter int MIN_PERIOD      = 5_000_000,
    parameter int SOFT_DROP_SHIFT = 3
) (
    input logic                    clk,
    input logic                    reset_n,
    tetris_gravity_timer_if.slave  bus
);
    localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int EW    = CNT_WIDTH + 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t               fsm_state;
    logic [CNT_WIDTH-1:0] count;
    logic                 next_fall_r;
    logic                 running_r;
    logic                 paused_r;
    logic [LVL_W-1:0]     level_r;
    logic [15:0]          lines_total_r;
    logic [19:0]          score_r;
    logic [15:0]          lines_in_level;

    logic [EW-1:0] drop;
    logic [EW-1:0] period_w;
    logic [EW-1:0] shifted_w;
    logic [EW-1:0] peff_w;
    logic          at_term;

    // Period arithmetic is done wide so a large level*step cannot wrap below the floor.
    always_comb begin
        drop = EW'(level_r) * EW'(PERIOD_STEP);
        if (EW'(BASE_PERIOD) > drop + EW'(MIN_PERIOD)) begin
            period_w = EW'(BASE_PERIOD) - drop;
        end else begin
            period_w = EW'(MIN_PERIOD);
        end
        shifted_w = period_w >> SOFT_DROP_SHIFT;
        if (shifted_w == '0) begin
            shifted_w = EW'(1);
        end
        peff_w  = bus.soft_drop ? shifted_w : period_w;
        at_term = EW'(count) >= (peff_w - EW'(1));
    end

    logic [15:0] ones;
    logic [2:0]  n_rows;
    logic [10:0] points;
    logic [31:0] award;
    logic [31:0] score_sum;
    logic [16:0] lines_sum;
    logic [15:0] lil_sum;
    logic        count_clear;

    always_comb begin
        ones = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            ones = ones + 16'(bus.lines_cleared[i]);
        end
        n_rows = (ones > 16'd4) ? 3'd4 : ones[2:0];
        case (n_rows)
            3'd1:    points = 11'd40;
            3'd2:    points = 11'd100;
            3'd3:    points = 11'd300;
            3'd4:    points = 11'd1200;
            default: points = 11'd0;
        endcase
        award       = 32'(points) * (32'(level_r) + 32'd1);
        score_sum   = 32'(score_r) + award;
        lines_sum   = 17'(lines_total_r) + 17'(n_rows);
        lil_sum     = lines_in_level + 16'(n_rows);
        count_clear = bus.lines_cleared_valid && (n_rows != 3'd0) &&
                      ((fsm_state == RUN) || (fsm_state == PAUSED));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_state      <= IDLE;
            count          <= '0;
            next_fall_r    <= 1'b0;
            running_r      <= 1'b0;
            paused_r       <= 1'b0;
            level_r        <= '0;
            lines_total_r  <= '0;
            score_r        <= '0;
            lines_in_level <= '0;
        end else begin
            next_fall_r <= 1'b0;
            if (bus.restart) begin
                fsm_state      <= IDLE;
                count          <= '0;
                running_r      <= 1'b0;
                paused_r       <= 1'b0;
                level_r        <= '0;
                lines_total_r  <= '0;
                score_r        <= '0;
                lines_in_level <= '0;
            end else begin
                if (count_clear) begin
                    score_r       <= (score_sum > 32'h000F_FFFF) ? 20'hF_FFFF : score_sum[19:0];
                    lines_total_r <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                    if (lil_sum >= 16'(LINES_PER_LEVEL)) begin
                        lines_in_level <= lil_sum - 16'(LINES_PER_LEVEL);
                        if (level_r != LVL_W'(NUM_LEVELS - 1)) begin
                            level_r <= level_r + 1'b1;
                        end
                    end else begin
                        lines_in_level <= lil_sum;
                    end
                end
                case (fsm_state)
                    IDLE: begin
                        if (bus.any_input) begin
                            fsm_state <= RUN;
                            count     <= '0;
                            running_r <= 1'b1;
                        end
                    end
                    RUN: begin
                        // A pause landing on the terminal count keeps the count, so the strobe fires after resume.
                        if (bus.game_over) begin
                            fsm_state <= OVER;
                            running_r <= 1'b0;
                        end else if (bus.pause_toggle) begin
                            fsm_state <= PAUSED;
                            running_r <= 1'b0;
                            paused_r  <= 1'b1;
                        end else if (at_term) begin
                            next_fall_r <= 1'b1;
                            count       <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (bus.game_over) begin
                            fsm_state <= OVER;
                            paused_r  <= 1'b0;
                        end else if (bus.pause_toggle) begin
                            fsm_state <= RUN;
                            running_r <= 1'b1;
                            paused_r  <= 1'b0;
                        end
                    end
                    default: begin
                        fsm_state <= OVER;
                    end
                endcase
            end
        end
    end

    assign bus.next_fall   = next_fall_r;
    assign bus.running     = running_r;
    assign bus.paused      = paused_r;
    assign bus.level       = level_r;
    assign bus.lines_total = lines_total_r;
    assign bus.score       = score_r;
    assign bus.state       = fsm_state;
endmodule

// File: tb/tb_tetris_gravity_timer.sv
// Directed bench for tetris_gravity_timer using small periods (BASE=20, STEP=4, MIN=6, SHIFT=1, LPL=4).
module tb_tetris_gravity_timer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    tetris_gravity_timer_if #(.NUM_LINES(20), .NUM_LEVELS(16)) bus();

    tetris_gravity_timer #(
        .CNT_WIDTH(26), .NUM_LINES(20), .NUM_LEVELS(16), .LINES_PER_LEVEL(4),
        .BASE_PERIOD(20), .PERIOD_STEP(4), .MIN_PERIOD(6), .SOFT_DROP_SHIFT(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input int max_cycles, output int n);
        n = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            tick();
            if (bus.next_fall === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic watch_no_fall(input int cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.next_fall !== 1'b0) seen = 1'b1;
        end
    endtask

    task automatic clear_rows(input logic [19:0] mask);
        bus.lines_cleared       = mask;
        bus.lines_cleared_valid = 1'b1;
        tick();
        bus.lines_cleared_valid = 1'b0;
        bus.lines_cleared       = '0;
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
    endtask

    task automatic start_play();
        bus.any_input = 1'b1;
        tick();
        bus.any_input = 1'b0;
    endtask

    task automatic toggle_pause();
        bus.pause_toggle = 1'b1;
        tick();
        bus.pause_toggle = 1'b0;
    endtask

    task automatic test_reset();
        logic [59:0] obs;
        tick();
        tick();
        obs = {bus.next_fall, bus.running, bus.paused, bus.level, bus.lines_total, bus.score, bus.state, 16'd0};
        tests_run++;
        if (obs !== 60'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        bit seen;
        logic [59:0] obs;
        watch_no_fall(100, seen);
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_fall: next_fall seen=%0d expected 0", seen);
        end
        obs = {bus.next_fall, bus.running, bus.paused, bus.level, bus.lines_total, bus.score, bus.state, 16'd0};
        tests_run++;
        if (obs !== 60'd0) begin
            tests_failed++;
            $display("FAIL idle_outputs: got %h expected 0", obs);
        end
    endtask

    task automatic test_fall_period();
        int n;
        start_play();
        tests_run++;
        if ({bus.running, bus.state} !== {1'b1, 2'd1}) begin
            tests_failed++;
            $display("FAIL run_entry: running/state=%b expected 101", {bus.running, bus.state});
        end
        for (int k = 0; k < 3; k++) begin
            wait_fall(40, n);
            tests_run++;
            if (n !== 20) begin
                tests_failed++;
                $display("FAIL fall_period_%0d: got %0d cycles expected 20", k, n);
            end
        end
    endtask

    task automatic test_line_clear();
        int n;
        clear_rows(20'h0000F);
        tests_run++;
        if ({bus.score, bus.lines_total, bus.level} !== {20'd1200, 16'd4, 4'd1}) begin
            tests_failed++;
            $display("FAIL clear_tetris: score=%0d lines=%0d level=%0d expected 1200/4/1",
                     bus.score, bus.lines_total, bus.level);
        end
        wait_fall(40, n);
        tests_run++;
        if (n !== 15) begin
            tests_failed++;
            $display("FAIL level1_first_fall: got %0d expected 15", n);
        end
        wait_fall(40, n);
        tests_run++;
        if (n !== 16) begin
            tests_failed++;
            $display("FAIL level1_period: got %0d expected 16", n);
        end
        clear_rows(20'h00007);
        tests_run++;
        if ({bus.score, bus.lines_total, bus.level} !== {20'd1800, 16'd7, 4'd1}) begin
            tests_failed++;
            $display("FAIL clear_three: score=%0d lines=%0d level=%0d expected 1800/7/1",
                     bus.score, bus.lines_total, bus.level);
        end
        clear_rows(20'h00030);
        tests_run++;
        if ({bus.score, bus.lines_total, bus.level} !== {20'd2000, 16'd9, 4'd2}) begin
            tests_failed++;
            $display("FAIL clear_two: score=%0d lines=%0d level=%0d expected 2000/9/2",
                     bus.score, bus.lines_total, bus.level);
        end
        clear_rows(20'h00FC0);
        tests_run++;
        if ({bus.score, bus.lines_total, bus.level} !== {20'd5600, 16'd13, 4'd3}) begin
            tests_failed++;
            $display("FAIL clear_six_as_four: score=%0d lines=%0d level=%0d expected 5600/13/3",
                     bus.score, bus.lines_total, bus.level);
        end
        clear_rows(20'h00000);
        bus.lines_cleared = 20'h0000F;
        tick();
        bus.lines_cleared = '0;
        tests_run++;
        if ({bus.score, bus.lines_total, bus.level} !== {20'd5600, 16'd13, 4'd3}) begin
            tests_failed++;
            $display("FAIL clear_empty_or_invalid: score=%0d lines=%0d level=%0d expected 5600/13/3",
                     bus.score, bus.lines_total, bus.level);
        end
    endtask

    task automatic test_soft_drop();
        int n;
        pulse_restart();
        clear_rows(20'h0000F);
        tests_run++;
        if ({bus.state, bus.score, bus.lines_total, bus.level} !== {2'd0, 20'd0, 16'd0, 4'd0}) begin
            tests_failed++;
            $display("FAIL idle_ignores_clear: state=%0d score=%0d lines=%0d level=%0d expected all 0",
                     bus.state, bus.score, bus.lines_total, bus.level);
        end
        start_play();
        repeat (15) tick();
        bus.soft_drop = 1'b1;
        wait_fall(40, n);
        tests_run++;
        if (n !== 1) begin
            tests_failed++;
            $display("FAIL soft_drop_immediate: got %0d expected 1", n);
        end
        for (int k = 0; k < 2; k++) begin
            wait_fall(40, n);
            tests_run++;
            if (n !== 10) begin
                tests_failed++;
                $display("FAIL soft_drop_period_%0d: got %0d expected 10", k, n);
            end
        end
        bus.soft_drop = 1'b0;
        wait_fall(40, n);
        tests_run++;
        if (n !== 20) begin
            tests_failed++;
            $display("FAIL soft_drop_release: got %0d expected 20", n);
        end
    endtask

    task automatic test_pause();
        int n;
        bit seen;
        pulse_restart();
        start_play();
        repeat (7) tick();
        toggle_pause();
        tests_run++;
        if ({bus.running, bus.paused, bus.state} !== {1'b0, 1'b1, 2'd2}) begin
            tests_failed++;
            $display("FAIL pause_enter: running/paused/state=%b expected 0110",
                     {bus.running, bus.paused, bus.state});
        end
        start_play();
        tests_run++;
        if (bus.paused !== 1'b1) begin
            tests_failed++;
            $display("FAIL pause_ignores_input: paused=%b expected 1", bus.paused);
        end
        watch_no_fall(48, seen);
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_no_fall: next_fall seen=%0d expected 0", seen);
        end
        toggle_pause();
        wait_fall(40, n);
        tests_run++;
        if (n !== 13) begin
            tests_failed++;
            $display("FAIL pause_resume_fall: got %0d expected 13", n);
        end
        repeat (19) tick();
        toggle_pause();
        tests_run++;
        if ({bus.next_fall, bus.paused} !== 2'b01) begin
            tests_failed++;
            $display("FAIL pause_at_terminal: next_fall/paused=%b expected 01", {bus.next_fall, bus.paused});
        end
        repeat (3) tick();
        toggle_pause();
        wait_fall(40, n);
        tests_run++;
        if (n !== 1) begin
            tests_failed++;
            $display("FAIL terminal_fires_on_resume: got %0d expected 1", n);
        end
    endtask

    task automatic test_game_over();
        bit seen;
        bus.game_over = 1'b1;
        clear_rows(20'h00001);
        bus.game_over = 1'b0;
        tests_run++;
        if ({bus.score, bus.lines_total, bus.running, bus.state} !== {20'd40, 16'd1, 1'b0, 2'd3}) begin
            tests_failed++;
            $display("FAIL over_with_clear: score=%0d lines=%0d running=%b state=%0d expected 40/1/0/3",
                     bus.score, bus.lines_total, bus.running, bus.state);
        end
        watch_no_fall(100, seen);
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL over_no_fall: next_fall seen=%0d expected 0", seen);
        end
        clear_rows(20'h0000F);
        start_play();
        toggle_pause();
        tests_run++;
        if ({bus.score, bus.state} !== {20'd40, 2'd3}) begin
            tests_failed++;
            $display("FAIL over_sticky: score=%0d state=%0d expected 40/3", bus.score, bus.state);
        end
        pulse_restart();
        tests_run++;
        if ({bus.state, bus.score, bus.lines_total, bus.level, bus.running} !== 43'd0) begin
            tests_failed++;
            $display("FAIL restart_clears: state=%0d score=%0d lines=%0d level=%0d expected all 0",
                     bus.state, bus.score, bus.lines_total, bus.level);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_play();
        bus.lines_cleared       = 20'h0000F;
        bus.lines_cleared_valid = 1'b1;
        repeat (17) tick();
        bus.lines_cleared_valid = 1'b0;
        bus.lines_cleared       = '0;
        tests_run++;
        if ({bus.score, bus.lines_total, bus.level} !== {20'd182400, 16'd68, 4'd15}) begin
            tests_failed++;
            $display("FAIL back_to_back_sat: score=%0d lines=%0d level=%0d expected 182400/68/15",
                     bus.score, bus.lines_total, bus.level);
        end
        wait_fall(40, n);
        wait_fall(40, n);
        tests_run++;
        if (n !== 6) begin
            tests_failed++;
            $display("FAIL min_period: got %0d expected 6", n);
        end
    endtask

    task automatic test_async_reset();
        logic [59:0] obs;
        pulse_restart();
        start_play();
        clear_rows(20'h00003);
        repeat (5) tick();
        tests_run++;
        if ({bus.score, bus.running} !== {20'd100, 1'b1}) begin
            tests_failed++;
            $display("FAIL pre_reset_run: score=%0d running=%b expected 100/1", bus.score, bus.running);
        end
        #2;
        reset_n = 1'b0;
        #1;
        obs = {bus.next_fall, bus.running, bus.paused, bus.level, bus.lines_total, bus.score, bus.state, 16'd0};
        tests_run++;
        if (obs !== 60'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected 0", obs);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.restart             = 1'b0;
        bus.any_input           = 1'b0;
        bus.pause_toggle        = 1'b0;
        bus.soft_drop           = 1'b0;
        bus.game_over           = 1'b0;
        bus.lines_cleared       = '0;
        bus.lines_cleared_valid = 1'b0;
        test_reset();
        test_idle();
        test_fall_period();
        test_line_clear();
        test_soft_drop();
        test_pause();
        test_game_over();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
